// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM loader: frame states, default sync marker and
// frame-format constants.
package rom_loader_pkg;

  typedef enum logic [3:0] {
    StSync,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StSumHi,
    StSumLo,
    StRun,
    StError
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int unsigned LEN_BITS = 16;
  localparam int unsigned SUM_BITS = 16;

  // A frame must carry at least one word and no more than the ROM holds.
  function automatic logic len_valid(input logic [LEN_BITS-1:0] len,
                                     input int unsigned addr_width);
    return (len != '0) && (32'(len) <= (32'd1 << addr_width));
  endfunction

  function automatic logic in_frame(input state_e st);
    return st inside {StLenHi, StLenLo, StDataHi, StDataLo, StSumHi, StSumLo};
  endfunction

endpackage

// File: rtl/rom_loader_rx_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags expiry on the
// cycle that would reach TIMEOUT_CYCLES. TIMEOUT_CYCLES of 0 disables it.
module rom_loader_rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CNT_W-1:0] count;

  assign expired = (TIMEOUT_CYCLES != 0) && enable && !clear && (count == CNT_W'(LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable || expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Writes a framed, checksummed byte stream into the instruction ROM and holds
// the CPU in reset until a complete frame has verified.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [15:0]           rom_wdata,
  output logic                  cpu_reset,
  output logic                  loaded,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  state_e              state;
  logic [LEN_BITS-1:0] length;
  logic [SUM_BITS-1:0] checksum;
  logic [7:0]          len_hi;
  logic [7:0]          hi_byte;
  logic                timeout;

  rom_loader_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid),
    .enable (in_frame(state)),
    .expired(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StSync;
      rom_we       <= 1'b0;
      rom_addr     <= '0;
      rom_wdata    <= '0;
      cpu_reset    <= 1'b1;
      loaded       <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      length       <= '0;
      checksum     <= '0;
      len_hi       <= '0;
      hi_byte      <= '0;
    end else begin
      rom_we <= 1'b0;
      // Bookkeeping trails the write pulse by one cycle; bytes are spaced so
      // this never collides with the next frame's sync clear.
      if (rom_we) begin
        rom_addr     <= rom_addr + 1'b1;
        checksum     <= checksum + rom_wdata;
        words_loaded <= words_loaded + 1'b1;
      end
      if (rx_valid) begin
        unique case (state)
          StSync, StRun, StError: begin
            if (rx_data == SYNC_BYTE) begin
              state        <= StLenHi;
              checksum     <= '0;
              words_loaded <= '0;
              rom_addr     <= '0;
              error        <= 1'b0;
              cpu_reset    <= 1'b1;
              loaded       <= 1'b0;
            end
          end
          StLenHi: begin
            len_hi <= rx_data;
            state  <= StLenLo;
          end
          StLenLo: begin
            if (len_valid({len_hi, rx_data}, ADDR_WIDTH)) begin
              length <= {len_hi, rx_data};
              state  <= StDataHi;
            end else begin
              state     <= StError;
              error     <= 1'b1;
              cpu_reset <= 1'b1;
              loaded    <= 1'b0;
            end
          end
          StDataHi: begin
            hi_byte <= rx_data;
            state   <= StDataLo;
          end
          StDataLo: begin
            rom_we    <= 1'b1;
            rom_wdata <= {hi_byte, rx_data};
            state     <= (LEN_BITS'(words_loaded) + 1'b1 == length) ? StSumHi : StDataHi;
          end
          StSumHi: begin
            hi_byte <= rx_data;
            state   <= StSumLo;
          end
          StSumLo: begin
            if ({hi_byte, rx_data} == checksum) begin
              state     <= StRun;
              cpu_reset <= 1'b0;
              loaded    <= 1'b1;
            end else begin
              state     <= StError;
              error     <= 1'b1;
              cpu_reset <= 1'b1;
              loaded    <= 1'b0;
            end
          end
          default: state <= StSync;
        endcase
      end else if (timeout) begin
        state     <= StError;
        error     <= 1'b1;
        cpu_reset <= 1'b1;
        loaded    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: framing, checksum, length
// limits, resync, inter-byte timeout and asynchronous reset.
module tb_rom_loader;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rom_we;
  logic [11:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic        loaded;
  logic        error;
  logic [12:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [11:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [15:0] frame_words[4096];

  rom_loader #(
    .ADDR_WIDTH    (12),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rom_we      (rom_we),
    .rom_addr    (rom_addr),
    .rom_wdata   (rom_wdata),
    .cpu_reset   (cpu_reset),
    .loaded      (loaded),
    .error       (error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rom_we) begin
      wr_addr.push_back(rom_addr);
      wr_data.push_back(rom_wdata);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Called at a negedge; one valid cycle then one idle cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_body(input int n, input logic [15:0] sum);
    logic [15:0] len;
    len = 16'(n);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < n; i++) begin
      send_byte(frame_words[i][15:8]);
      send_byte(frame_words[i][7:0]);
    end
    send_byte(sum[15:8]);
    send_byte(sum[7:0]);
  endtask

  task automatic send_frame(input int n, input logic [15:0] sum);
    send_byte(8'hA5);
    send_body(n, sum);
  endtask

  task automatic test_reset();
    checks++;
    if ({rom_we, cpu_reset, loaded, error} !== 4'b0100 || rom_addr !== 12'h000 ||
        rom_wdata !== 16'h0000 || words_loaded !== 13'h0000) begin
      errors++;
      $display("FAIL reset_values: we/cpu_rst/loaded/err=%b addr=%h wdata=%h words=%h, want 0100 0 0 0",
               {rom_we, cpu_reset, loaded, error}, rom_addr, rom_wdata, words_loaded);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rom_we, cpu_reset, loaded, error} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_release: got %b want 0100", {rom_we, cpu_reset, loaded, error});
    end
  endtask

  task automatic test_noise();
    clear_log();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    checks++;
    if (wr_addr.size() != 0) begin
      errors++;
      $display("FAIL noise_writes: got %0d writes want 0", wr_addr.size());
    end
    checks++;
    if ({cpu_reset, loaded, error} !== 3'b100) begin
      errors++;
      $display("FAIL noise_flags: cpu_rst/loaded/err=%b want 100", {cpu_reset, loaded, error});
    end
  endtask

  task automatic test_good_frame();
    clear_log();
    frame_words[0] = 16'h1234;
    frame_words[1] = 16'hABCD;
    send_frame(2, 16'hBE01);
    checks++;
    if (wr_addr.size() != 2) begin
      errors++;
      $display("FAIL good_write_count: got %0d want 2", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 12'h000 || wr_data[0] !== 16'h1234 ||
          wr_addr[1] !== 12'h001 || wr_data[1] !== 16'hABCD) begin
        errors++;
        $display("FAIL good_writes: got %h:%h %h:%h want 000:1234 001:abcd",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
    checks++;
    if ({cpu_reset, loaded, error} !== 3'b010 || words_loaded !== 13'd2) begin
      errors++;
      $display("FAIL good_run: cpu_rst/loaded/err=%b words=%0d want 010 2",
               {cpu_reset, loaded, error}, words_loaded);
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    frame_words[0] = 16'h1234;
    frame_words[1] = 16'hABCD;
    send_frame(2, 16'hBE02);
    checks++;
    if (wr_addr.size() != 2) begin
      errors++;
      $display("FAIL badsum_write_count: got %0d want 2", wr_addr.size());
    end
    checks++;
    if ({cpu_reset, loaded, error} !== 3'b101) begin
      errors++;
      $display("FAIL badsum_flags: cpu_rst/loaded/err=%b want 101", {cpu_reset, loaded, error});
    end
    send_frame(2, 16'hBE01);
    checks++;
    if ({cpu_reset, loaded, error} !== 3'b010) begin
      errors++;
      $display("FAIL badsum_recover: cpu_rst/loaded/err=%b want 010", {cpu_reset, loaded, error});
    end
  endtask

  task automatic test_length();
    logic [15:0] sum;
    int bad;
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if ({cpu_reset, loaded, error} !== 3'b101) begin
      errors++;
      $display("FAIL len_zero: cpu_rst/loaded/err=%b want 101", {cpu_reset, loaded, error});
    end
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h01);
    checks++;
    if ({cpu_reset, loaded, error} !== 3'b101 || wr_addr.size() != 0) begin
      errors++;
      $display("FAIL len_4097: cpu_rst/loaded/err=%b writes=%0d want 101 0",
               {cpu_reset, loaded, error}, wr_addr.size());
    end
    sum = 16'h0000;
    for (int i = 0; i < 4096; i++) begin
      frame_words[i] = 16'(i * 257 + 5);
      sum = sum + frame_words[i];
    end
    send_frame(4096, sum);
    checks++;
    if (wr_addr.size() != 4096) begin
      errors++;
      $display("FAIL len_max_count: got %0d writes want 4096", wr_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 4096; i++)
        if (wr_addr[i] !== 12'(i) || wr_data[i] !== frame_words[i]) bad++;
      checks++;
      if (bad != 0 || wr_addr[4095] !== 12'hFFF) begin
        errors++;
        $display("FAIL len_max_writes: %0d bad writes, last addr %h want 0 fff", bad, wr_addr[4095]);
      end
    end
    checks++;
    if ({cpu_reset, loaded, error} !== 3'b010 || words_loaded !== 13'h1000) begin
      errors++;
      $display("FAIL len_max_run: cpu_rst/loaded/err=%b words=%h want 010 1000",
               {cpu_reset, loaded, error}, words_loaded);
    end
  endtask

  // Reload while running; the payload also contains the sync value as data.
  task automatic test_back_to_back();
    clear_log();
    frame_words[0] = 16'hA5A5;
    frame_words[1] = 16'h0001;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(negedge clk);
    checks++;
    if ({cpu_reset, loaded} !== 2'b10) begin
      errors++;
      $display("FAIL resync_accept: cpu_rst/loaded=%b want 10", {cpu_reset, loaded});
    end
    rx_valid = 1'b0;
    @(negedge clk);
    send_body(2, 16'hA5A6);
    checks++;
    if (wr_addr.size() != 2) begin
      errors++;
      $display("FAIL resync_write_count: got %0d want 2", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 12'h000 || wr_data[0] !== 16'hA5A5 ||
          wr_addr[1] !== 12'h001 || wr_data[1] !== 16'h0001) begin
        errors++;
        $display("FAIL resync_writes: got %h:%h %h:%h want 000:a5a5 001:0001",
                 wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
    checks++;
    if ({cpu_reset, loaded, error} !== 3'b010) begin
      errors++;
      $display("FAIL resync_run: cpu_rst/loaded/err=%b want 010", {cpu_reset, loaded, error});
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (48) @(negedge clk);  // 49 idle cycles in total
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_49_idle: error=%b want 0", error);
    end
    @(negedge clk);
    checks++;
    if ({cpu_reset, loaded, error} !== 3'b101) begin
      errors++;
      $display("FAIL timeout_50_idle: cpu_rst/loaded/err=%b want 101", {cpu_reset, loaded, error});
    end
    clear_log();
    frame_words[0] = 16'h1234;
    send_byte(8'hA5); repeat (48) @(negedge clk);
    send_byte(8'h00); repeat (48) @(negedge clk);
    send_byte(8'h01); repeat (48) @(negedge clk);
    send_byte(8'h12); repeat (48) @(negedge clk);
    send_byte(8'h34); repeat (48) @(negedge clk);
    send_byte(8'h12); repeat (48) @(negedge clk);
    send_byte(8'h34);
    checks++;
    if ({cpu_reset, loaded, error} !== 3'b010 || wr_addr.size() != 1) begin
      errors++;
      $display("FAIL timeout_slow_frame: cpu_rst/loaded/err=%b writes=%0d want 010 1",
               {cpu_reset, loaded, error}, wr_addr.size());
    end
  endtask

  task automatic test_async_reset();
    frame_words[0] = 16'h1111;
    frame_words[1] = 16'h2222;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h03);
    for (int i = 0; i < 2; i++) begin
      send_byte(frame_words[i][15:8]);
      send_byte(frame_words[i][7:0]);
    end
    send_byte(8'h33);
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (rom_we !== 1'b1 || rom_addr !== 12'h002 || words_loaded !== 13'd2) begin
      errors++;
      $display("FAIL mid_frame_write: we=%b addr=%h words=%0d want 1 002 2",
               rom_we, rom_addr, words_loaded);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({rom_we, cpu_reset, loaded, error} !== 4'b0100 || rom_addr !== 12'h000 ||
        rom_wdata !== 16'h0000 || words_loaded !== 13'h0000) begin
      errors++;
      $display("FAIL async_reset: we/cpu_rst/loaded/err=%b addr=%h wdata=%h words=%h want 0100 0 0 0",
               {rom_we, cpu_reset, loaded, error}, rom_addr, rom_wdata, words_loaded);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    frame_words[0] = 16'h1234;
    frame_words[1] = 16'hABCD;
    send_frame(2, 16'hBE01);
    checks++;
    if (wr_addr.size() != 2 || {cpu_reset, loaded, error} !== 3'b010) begin
      errors++;
      $display("FAIL post_reset_frame: writes=%0d cpu_rst/loaded/err=%b want 2 010",
               wr_addr.size(), {cpu_reset, loaded, error});
    end else begin
      checks++;
      if (wr_addr[0] !== 12'h000 || wr_data[0] !== 16'h1234 || wr_addr[1] !== 12'h001) begin
        errors++;
        $display("FAIL post_reset_addr: got %h:%h %h want 000:1234 001",
                 wr_addr[0], wr_data[0], wr_addr[1]);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_noise();
    test_good_frame();
    test_bad_checksum();
    test_length();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
